signed_div_unit: RTL
====================

Name: signed_div_unit

Overview:
- Iterative 32-bit signed divider (radix-2, restoring), acting as responder to the control unit's divide handshake (start / done / div0).
- Sits beside the existing multiply unit. Operands come from the A and B register outputs.
- Quotient feeds the LO write mux and remainder feeds the HI write mux.
- Implements MIPS div semantics: quotient truncates toward zero; remainder takes the dividend's sign.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 6, width of iteration counter (must hold WIDTH)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request from control unit; sampled only in IDLE
dividend  input  WIDTH  signed dividend (A register output)
divisor  input  WIDTH  signed divisor (B register output)
busy  output  1  high while an operation is in progress (not IDLE)
done  output  1  one-cycle pulse: result valid / operation finished
div0  output  1  one-cycle pulse coincident with done when divisor was zero
hi  output  WIDTH  remainder, held until next successful result
lo  output  WIDTH  quotient, held until next successful result

Behaviour:
- Reset (reset=0, any time, async):
  - state=IDLE; hi=lo=0; done=div0=busy=0; internal registers cleared.
  - Any operation in flight is abandoned; no done is produced for it.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On a rising edge with start=1, latch dividend and divisor (cycle 0 = this edge).
  - If divisor==0: go to DONE with div0 flagged. hi/lo are NOT modified.
  - Else: record sign_q = dividend[MSB] XOR divisor[MSB] and sign_r = dividend[MSB].
  - Load magnitude |dividend| into the quotient shift register and |divisor| into the divisor register. Clear the partial remainder (WIDTH+1 bits). Set count=0. Go to RUN.
  - |0x80000000| = 0x80000000, treated as unsigned 2^31.
- RUN, one quotient bit per cycle:
  - Shift {rem, quo} left 1.
  - trial = rem - dvs (WIDTH+1-bit subtract).
  - If trial is non-negative: rem=trial and the quo LSB becomes 1. Otherwise the quo LSB becomes 0.
  - count increments each cycle. After the WIDTH-th iteration (count==WIDTH-1 on that edge), go to FIX.
- FIX:
  - lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem. Both are registered at the FIX→DONE edge.
  - Results are truncated to WIDTH (two's complement).
- DONE:
  - done=1 for exactly this cycle. div0=1 in this cycle only if the divisor-zero path was taken.
  - Goes to IDLE unconditionally on the next edge.
- Latency:
  - Normal: start sampled at edge 0; RUN spans edges 1..32; FIX→DONE at edge 33. done is high in the cycle after edge 33, and hi/lo are valid from that same cycle.
  - Divide by zero: done=div0=1 in the cycle after edge 1.
- busy=1 in RUN, FIX, DONE. start is ignored whenever busy=1.
- Operands may change after cycle 0 without effect.
- The control unit must deassert start by the DONE cycle. A start still high in IDLE after DONE begins a new operation (defined behaviour, not an error).
- Overflow case 0x80000000 / 0xFFFFFFFF:
  - lo=0x80000000, hi=0, div0=0.
  - No trap is raised; wrap-around is intentional.
- Zero dividend with non-zero divisor: lo=0, hi=0 (no negative-zero issues).
- hi/lo change only at the FIX→DONE edge or on reset. Outside those they hold, so the control unit may write HI/LO any cycle from done onward.
- done and div0 are never high outside DONE. div0 never high without done.

Test Plan:
- Basic: reset low 2 cycles then high; start=1 for 1 cycle, dividend=100, divisor=7 → busy=1 next cycle; done pulse 33 edges later; lo=14, hi=2, div0=0.
- Signs:
  - -100/7 → lo=0xFFFFFFF2, hi=0xFFFFFFFE.
  - 100/-7 → lo=0xFFFFFFF2, hi=2.
  - -100/-7 → lo=14, hi=0xFFFFFFFE.
- Boundary:
  - 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, div0=0.
  - 0x7FFFFFFF/1 → lo=0x7FFFFFFF, hi=0.
  - 5/9 → lo=0, hi=5.
- Divide by zero: preload hi/lo via 100/7, then start with divisor=0 → done=div0=1 one cycle after the start edge; hi=2, lo=14 unchanged; busy low the following cycle.
- Protocol:
  - Pulse start again at RUN cycle 5 with new operands → ignored; original result delivered on schedule.
  - Start held high through DONE → a second operation begins immediately after returning to IDLE.
- Reset mid-operation: assert reset at RUN cycle 10 → hi=lo=0, busy=0 immediately (async); no done pulse ever appears for that operation. Next start 42/5 → lo=8, hi=2.

Source files
------------

// File: rtl/signed_div_unit_if.sv
// Divide handshake between the control unit (master) and the divider (slave).
// Operands come in from the A/B registers; quotient/remainder go out to LO/HI.
interface signed_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/signed_div_unit.sv
// Iterative radix-2 restoring signed divider with MIPS div semantics:
// quotient truncates toward zero, remainder carries the dividend's sign.
// One quotient bit per cycle on operand magnitudes; signs fixed up at the end.
module signed_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    signed_div_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH:0]   rem_q;       // partial remainder, one guard bit for the trial subtract
    logic [WIDTH-1:0] quo_q;       // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q;       // divisor magnitude
    logic [CNT_W-1:0] count_q;
    logic             sign_quo_q;  // quotient must be negated
    logic             sign_rem_q;  // remainder must be negated
    logic             zero_q;      // divisor-zero operation in flight
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             div0_q;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [2*WIDTH:0] pair_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    // Magnitudes, one restoring step, and the sign fix-up of the final result.
    always_comb begin
        // NOTE: every comb output gets a value on every path, so no latch is inferred.
        // The most negative value negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
        dvd_mag    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        dvs_mag    = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

        pair_shift = {rem_q, quo_q} << 1;
        trial      = pair_shift[2*WIDTH:WIDTH] - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_d = trial;
            quo_d = {pair_shift[WIDTH-1:1], 1'b1};
        end else begin
            rem_d = pair_shift[2*WIDTH:WIDTH];
            quo_d = {pair_shift[WIDTH-1:1], 1'b0};
        end

        // Negating a zero magnitude yields zero, so there is no negative-zero case.
        lo_d = sign_quo_q ? -quo_q : quo_q;
        hi_d = sign_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    // Control FSM and datapath registers; all handshake outputs are registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            count_q    <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            zero_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div0_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    div0_q <= 1'b0;
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.divisor == '0) begin
                            // Pass through FIX without touching HI/LO so div0 lands with done.
                            zero_q  <= 1'b1;
                            state_q <= FIX;
                        end else begin
                            zero_q     <= 1'b0;
                            sign_quo_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            sign_rem_q <= bus.dividend[WIDTH-1];
                            quo_q      <= dvd_mag;
                            dvs_q      <= dvs_mag;
                            rem_q      <= '0;
                            count_q    <= '0;
                            state_q    <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (!zero_q) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
                    div0_q  <= zero_q;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    div0_q  <= 1'b0;
                    zero_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
